// File: rtl/mult_inverse_divider.sv
// mult_inverse_divider: restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per cycle.
// Optional build macro EARLY_EXIT_EN: finish in the accept cycle when B == 0 or P < B.
module mult_inverse_divider #(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] P,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   R,
  output logic           div_zero
);

  localparam int CW = (2 * N > 2) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           dz_q, dz_d;
  logic [2*N-1:0] q_q, q_d;
  logic [N-1:0]   r_q, r_d;

  // Dividend bits leave pq from the top while quotient bits enter at the bottom.
  logic [2*N-1:0] pq_q, pq_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   rem_q, rem_d;

  logic [N:0]     rem_shift;
  logic           ge;
  logic [N-1:0]   rem_next;
  logic [2*N-1:0] pq_next;

  always_comb begin
    rem_shift = {rem_q, pq_q[2*N-1]};
    ge        = (rem_shift >= {1'b0, b_q});
    rem_next  = ge ? (rem_shift[N-1:0] - b_q) : rem_shift[N-1:0];
    pq_next   = {pq_q[2*N-2:0], ge};

    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dz_d        = dz_q;
    q_d         = q_q;
    r_d         = r_q;
    pq_d        = pq_q;
    b_d         = b_q;
    rem_d       = rem_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          pq_d       = P;
          b_d        = B;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
`ifdef EARLY_EXIT_EN
          if (B == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            q_d         = '1;
            r_d         = '0;
            dz_d        = 1'b1;
          end else if ({{N{1'b0}}, B} > P) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            q_d         = '0;
            r_d         = P[N-1:0];
            dz_d        = 1'b0;
          end
`endif
        end
      end

      CALC: begin
        pq_d  = pq_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          // A zero divisor lets the remainder run away; the result is forced instead.
          dz_d        = (b_q == '0);
          q_d         = (b_q == '0) ? '1 : pq_next;
          r_d         = (b_q == '0) ? '0 : rem_next;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dz_q        <= dz_d;
      q_q         <= q_d;
      r_q         <= r_d;
    end
  end

  // Working datapath is always reloaded on accept, so it carries no reset.
  always_ff @(posedge clk) begin
    pq_q  <= pq_d;
    b_q   <= b_d;
    rem_q <= rem_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_q;
  assign R         = r_q;
  assign div_zero  = dz_q;

endmodule
